// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'd0;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-pc selection: hold, +4, or redirect, then a bound check.
// With FETCH_BOUND_TRAP_EN, an illegal next pc raises trap; otherwise it is aligned and wrapped.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic [63:0] pc,
  input  logic        advance,
  input  logic        redir_valid,
  input  logic [63:0] redir_pc,
  output logic [63:0] pc_next,
  output logic        trap
);

  logic [63:0] cand;
  logic        update;

  always_comb begin
    update = redir_valid | advance;
    if (redir_valid)  cand = redir_pc;
    else if (advance) cand = pc + 64'(INSTR_BYTES);
    else              cand = pc;
  end

`ifdef FETCH_BOUND_TRAP_EN
  // Widen by one bit so a target near 2^64 cannot wrap past the bound check.
  logic [64:0] last_byte;
  assign last_byte = {1'b0, cand} + 65'd3;
  assign trap      = update & ((cand[1:0] != 2'b00) | (last_byte >= 65'(IMEM_BYTES)));
  assign pc_next   = trap ? pc : cand;
`else
  assign trap    = 1'b0;
  assign pc_next = {cand[63:2], 2'b00} & 64'(IMEM_BYTES - 1);
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: pc/state/count registers with a ready/valid output to decode.
// Optional macro FETCH_BOUND_TRAP_EN enables trapping on misaligned or out-of-range fetches.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        redir_valid,
  input  logic [63:0] redir_pc,
  output logic        fault,
  output logic [31:0] instr_count
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [31:0]  count_q;
  logic         active, redir_eff, hs, trap;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign active    = (state_q == IDLE) | (state_q == RUN);
  assign redir_eff = active & redir_valid;
  assign out_valid = (state_q == RUN) & ~redir_valid;
  assign hs        = out_valid & out_ready;

  fetch_pc_next #(
    .IMEM_BYTES(IMEM_BYTES)
  ) u_pc_next (
    .pc         (pc_q),
    .advance    (hs),
    .redir_valid(redir_eff),
    .redir_pc   (redir_pc),
    .pc_next    (pc_d),
    .trap       (trap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = trap ? FAULT : RUN;
      RUN:     state_d = trap ? FAULT : RUN;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (active) pc_q <= pc_d;
      if (hs)     count_q <= sat_inc(count_q);
    end
  end

  assign imem_addr   = pc_q;
  assign out_pc      = pc_q;
  assign out_instr   = imem_instr;
  assign instr_count = count_q;

`ifdef FETCH_BOUND_TRAP_EN
  assign fault = (state_q == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a large-memory instance for flow tests, a 16-byte one for bounds.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, s_reset;
  logic [63:0] imem_addr, out_pc, redir_pc;
  logic [31:0] imem_instr, out_instr, instr_count;
  logic        out_valid, out_ready, redir_valid, fault;

  logic [63:0] s_addr, s_pc, s_redir_pc;
  logic [31:0] s_imem, s_instr, s_count;
  logic        s_valid, s_ready, s_redir, s_fault;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] instr_hold;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_instr = mem_word(imem_addr);
  assign s_imem     = mem_word(s_addr);

  instr_fetch #(.IMEM_BYTES(1024), .RESET_PC(64'd0)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .fault(fault), .instr_count(instr_count)
  );

  instr_fetch #(.IMEM_BYTES(16), .RESET_PC(64'd0)) u_small (
    .clk(clk), .reset(s_reset), .imem_addr(s_addr), .imem_instr(s_imem),
    .out_valid(s_valid), .out_ready(s_ready), .out_instr(s_instr), .out_pc(s_pc),
    .redir_valid(s_redir), .redir_pc(s_redir_pc), .fault(s_fault), .instr_count(s_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake on the main instance must match the next queued pc.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc 0x%0h with empty queue", out_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (out_pc !== e || out_instr !== mem_word(e)) begin
          errors++;
          $display("FAIL sb_xfer: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                   out_pc, out_instr, e, mem_word(e));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; s_reset = 1'b1;
    out_ready = 1'b0; redir_valid = 1'b0; redir_pc = 64'd0;
    s_ready = 1'b0; s_redir = 1'b0; s_redir_pc = 64'd0;
    repeat (2) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    step();

    // Sequential fetch with decode always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'(i * 4));
      step();
    end
    out_ready = 1'b0;
    chk("seq_count", 64'(instr_count), 64'd4);
    chk("seq_pc", out_pc, 64'd16);

    redir_valid = 1'b1; redir_pc = 64'd8;
    @(negedge clk);
    chk("redir8_squash", 64'(out_valid), 64'd0);
    step();
    redir_valid = 1'b0;

    // Stall at pc 8.
    instr_hold = out_instr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc", out_pc, 64'd8);
      chk("stall_instr", 64'(out_instr), 64'(instr_hold));
      chk("stall_valid", 64'(out_valid), 64'd1);
      step();
    end
    chk("stall_count", 64'(instr_count), 64'd4);
    out_ready = 1'b1;
    exp_q.push_back(64'd8);  step();
    exp_q.push_back(64'd12); step();
    out_ready = 1'b0;
    chk("resume_count", 64'(instr_count), 64'd6);
    chk("resume_pc", out_pc, 64'h10);

    // Redirect with ready high squashes the handshake.
    redir_valid = 1'b1; redir_pc = 64'h40; out_ready = 1'b1;
    @(negedge clk);
    chk("squash_valid", 64'(out_valid), 64'd0);
    step();
    redir_valid = 1'b0; out_ready = 1'b0;
    chk("squash_count", 64'(instr_count), 64'd6);
    chk("redir_pc", out_pc, 64'h40);
    out_ready = 1'b1;
    exp_q.push_back(64'h40); step();
    out_ready = 1'b0;
    chk("post_redir_count", 64'(instr_count), 64'd7);

    // Asynchronous reset while stalled at 0x20.
    redir_valid = 1'b1; redir_pc = 64'h20;
    step();
    redir_valid = 1'b0;
    @(negedge clk);
    chk("pre_areset_pc", out_pc, 64'h20);
    chk("pre_areset_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", 64'(out_valid), 64'd0);
    chk("areset_pc", out_pc, 64'd0);
    chk("areset_count", 64'(instr_count), 64'd0);
    chk("areset_fault", 64'(fault), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rearm_idle", 64'(out_valid), 64'd0);
    step();
    out_ready = 1'b1;
    exp_q.push_back(64'd0); step();
    out_ready = 1'b0;
    chk("refetch_count", 64'(instr_count), 64'd1);
    chk("refetch_pc", out_pc, 64'd4);

    // Small memory: bound behaviour at the 16-byte edge.
    s_reset = 1'b0;
    step();
    s_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("small_pc", s_pc, 64'(i * 4));
      chk("small_valid", 64'(s_valid), 64'd1);
      step();
    end
    chk("small_count", 64'(s_count), 64'd4);
`ifdef FETCH_BOUND_TRAP_EN
    chk("trap_fault", 64'(s_fault), 64'd1);
    chk("trap_valid", 64'(s_valid), 64'd0);
    chk("trap_pc", s_pc, 64'd12);
    s_redir = 1'b1; s_redir_pc = 64'd0;
    step();
    s_redir = 1'b0;
    chk("trap_redir_pc", s_pc, 64'd12);
    chk("trap_sticky", 64'(s_fault), 64'd1);
    chk("trap_count_hold", 64'(s_count), 64'd4);
`else
    chk("wrap_pc", s_pc, 64'd0);
    chk("wrap_fault", 64'(s_fault), 64'd0);
    chk("wrap_valid", 64'(s_valid), 64'd1);
    step();
    s_ready = 1'b0;
    chk("wrap_adv_pc", s_pc, 64'd4);
    s_redir = 1'b1; s_redir_pc = 64'h42;
    step();
    s_redir = 1'b0;
    chk("mask_redir_pc", s_pc, 64'd0);
    chk("mask_count", 64'(s_count), 64'd5);
`endif
    s_ready = 1'b0;

    step();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
